uart_rx_fifo: RTL

//  UART receiver in the user project, fed from mprj_io[5], which the bench UART drives.

---
 rtl/uart_rx_fifo.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver (LSB first, idle-high) feeding a first-word-fall-through byte FIFO.
// Framing errors pulse frame_err; a push into a full FIFO sets sticky overrun.
module uart_rx_fifo #(
  parameter int DEPTH   = 4,
  parameter int DIV_MIN = 4
) (
  input  logic                   wb_clk_i,
  input  logic                   wb_rst_i,
  input  logic                   rx,
  input  logic [15:0]            clk_div,
  output logic [7:0]             rx_data,
  output logic                   rx_valid,
  input  logic                   rx_pop,
  output logic [$clog2(DEPTH):0] rx_count,
  output logic                   frame_err,
  output logic                   overrun,
  input  logic                   err_clr,
  output logic                   busy
);
  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t      state_q, state_d;
  logic        rx_meta_q, rxs_q;
  logic [15:0] cnt_q, cnt_d, div_q, div_d, div_in;
  logic [2:0]  bit_q, bit_d;
  logic [7:0]  sh_q, sh_d;
  logic        wait_hi_q, wait_hi_d, ferr_q, ferr_d, ovr_q, ovr_d;
  logic        push, full, empty, do_pop, do_push;
  logic [AW:0] wptr_q, wptr_d, rptr_q, rptr_d, count;
  logic [7:0]  mem_q [DEPTH];

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      rx_meta_q <= 1'b1;
      rxs_q     <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rxs_q     <= rx_meta_q;
    end
  end

  assign div_in = (clk_div < 16'(DIV_MIN)) ? 16'(DIV_MIN) : clk_div;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    div_d     = div_q;
    bit_d     = bit_q;
    sh_d      = sh_q;
    wait_hi_d = wait_hi_q;
    ferr_d    = 1'b0;
    push      = 1'b0;
    case (state_q)
      IDLE: begin
        // After a bad stop bit, hold off until the line goes high so a break cannot retrigger.
        if (wait_hi_q) begin
          if (rxs_q) wait_hi_d = 1'b0;
        end else if (!rxs_q) begin
          state_d = START;
          div_d   = div_in;
          cnt_d   = (div_in >> 1) - 16'd1;
        end
      end
      START: begin
        if (cnt_q != 16'd0) cnt_d = cnt_q - 16'd1;
        else if (rxs_q) state_d = IDLE;
        else begin
          state_d = DATA;
          cnt_d   = div_q - 16'd1;
          bit_d   = 3'd0;
        end
      end
      DATA: begin
        if (cnt_q != 16'd0) cnt_d = cnt_q - 16'd1;
        else begin
          sh_d  = {rxs_q, sh_q[7:1]};
          cnt_d = div_q - 16'd1;
          bit_d = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = STOP;
        end
      end
      STOP: begin
        // Sampled mid-stop-bit; returning to IDLE here lets back-to-back frames through.
        if (cnt_q != 16'd0) cnt_d = cnt_q - 16'd1;
        else begin
          state_d = IDLE;
          if (rxs_q) push = 1'b1;
          else begin
            ferr_d    = 1'b1;
            wait_hi_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign count   = wptr_q - rptr_q;
  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = rx_pop && !empty;
  // A simultaneous pop frees the slot, so a full FIFO still accepts the push.
  assign do_push = push && (!full || do_pop);

  always_comb begin
    wptr_d = wptr_q + {{AW{1'b0}}, do_push};
    rptr_d = rptr_q + {{AW{1'b0}}, do_pop};
    ovr_d  = ovr_q;
    if (err_clr)           ovr_d = 1'b0;
    if (push && !do_push)  ovr_d = 1'b1;
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      div_q     <= '0;
      bit_q     <= '0;
      sh_q      <= '0;
      wait_hi_q <= 1'b0;
      ferr_q    <= 1'b0;
      ovr_q     <= 1'b0;
      wptr_q    <= '0;
      rptr_q    <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      div_q     <= div_d;
      bit_q     <= bit_d;
      sh_q      <= sh_d;
      wait_hi_q <= wait_hi_d;
      ferr_q    <= ferr_d;
      ovr_q     <= ovr_d;
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (do_push) mem_q[wptr_q[AW-1:0]] <= sh_q;
  end

  assign rx_data   = empty ? 8'h00 : mem_q[rptr_q[AW-1:0]];
  assign rx_valid  = !empty;
  assign rx_count  = count;
  assign frame_err = ferr_q;
  assign overrun   = ovr_q;
  assign busy      = (state_q != IDLE);

endmodule
